// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
// The main register drives out_data directly. The skid register catches the one
// extra beat that can arrive while downstream stalls. in_ready and out_valid are
// decoded from the registered state only, so the ready path is never combinational
// through the stage. Saturating counters track stall and bubble cycles.
module pipe_stage_skid #(
    parameter int unsigned      WIDTH     = 64,
    parameter logic [WIDTH-1:0] NOP_VALUE = {WIDTH{1'b0}},
    parameter int unsigned      CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    state_e           state_q;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    // Handshake flags come straight from the state register.
    assign in_ready  = (state_q != StTwo);
    assign out_valid = (state_q != StEmpty);
    // main_q is forced to NOP_VALUE whenever it stops holding a valid entry.
    assign out_data  = main_q;

    // Occupancy FSM and payload registers; Reset and Flush both empty the stage.
    always_ff @(posedge CLK) begin
        if (Reset || Flush) begin
            state_q <= StEmpty;
            main_q  <= NOP_VALUE;
            skid_q  <= NOP_VALUE;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (in_valid) begin
                        main_q  <= in_data;
                        state_q <= StOne;
                    end
                end
                StOne: begin
                    if (out_ready) begin
                        if (in_valid) begin
                            // Pass-through at full throughput.
                            main_q <= in_data;
                        end else begin
                            main_q  <= NOP_VALUE;
                            state_q <= StEmpty;
                        end
                    end else if (in_valid) begin
                        // Downstream stalled: park the new beat behind main.
                        skid_q  <= in_data;
                        state_q <= StTwo;
                    end
                end
                StTwo: begin
                    // in_ready is low here, so in_valid is ignored.
                    if (out_ready) begin
                        main_q  <= skid_q;
                        skid_q  <= NOP_VALUE;
                        state_q <= StOne;
                    end
                end
                default: begin
                    state_q <= StEmpty;
                    main_q  <= NOP_VALUE;
                    skid_q  <= NOP_VALUE;
                end
            endcase
        end
    end

    // Saturating performance counters, driven by pre-edge handshake levels.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_cnt != CntMax)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (!out_valid && out_ready && (bubble_cnt != CntMax)) begin
                bubble_cnt <= bubble_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid. Two instances share the stimulus: a
// wide-counter one with zero NOP, and a 4-bit-counter one with a non-zero NOP to
// expose saturation and NOP handling. The reference model is a FIFO of at most
// two entries plus raw (unbounded) cycle counts.
module tb_pipe_stage_skid;

    localparam int unsigned W     = 32;
    localparam logic [W-1:0] NOP_S = 32'hDEAD_BEEF;

    logic          CLK = 1'b0;
    logic          Reset = 1'b1;
    logic          Flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          out_ready = 1'b0;

    logic          in_ready, out_valid;
    logic [W-1:0]  out_data;
    logic [15:0]   stall_cnt, bubble_cnt;
    logic          in_ready_s, out_valid_s;
    logic [W-1:0]  out_data_s;
    logic [3:0]    stall_s, bubble_s;

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    // Reference model state
    logic [W-1:0]  mq[$];
    int unsigned   stall_raw = 0;
    int unsigned   bubble_raw = 0;

    always #5 CLK = ~CLK;

    pipe_stage_skid #(.WIDTH(W), .NOP_VALUE('0), .CNT_W(16)) dut (
        .CLK(CLK), .Reset(Reset), .Flush(Flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    pipe_stage_skid #(.WIDTH(W), .NOP_VALUE(NOP_S), .CNT_W(4)) dut_s (
        .CLK(CLK), .Reset(Reset), .Flush(Flush),
        .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
        .stall_cnt(stall_s), .bubble_cnt(bubble_s)
    );

    function automatic logic [15:0] sat16(int unsigned r);
        return (r > 32'd65535) ? 16'hFFFF : r[15:0];
    endfunction

    function automatic logic [3:0] sat4(int unsigned r);
        return (r > 32'd15) ? 4'hF : r[3:0];
    endfunction

    // One clock edge: advance the model from pre-edge inputs, then settle.
    task automatic step();
        logic ov, ir;
        @(posedge CLK);
        ov = (mq.size() > 0);
        ir = (mq.size() < 2);
        if (Reset) begin
            mq.delete();
            stall_raw  = 0;
            bubble_raw = 0;
        end else begin
            if (ov && !out_ready) stall_raw++;
            if (!ov && out_ready) bubble_raw++;
            if (Flush) begin
                mq.delete();
            end else begin
                if (ov && out_ready) void'(mq.pop_front());
                if (in_valid && ir) mq.push_back(in_data);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; Flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step(); step();
        n_checks++;
        if (stall_cnt !== 16'd0 || bubble_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: got stall=%0d bubble=%0d want 0/0", stall_cnt, bubble_cnt);
        end
        Reset = 1'b0;
        step(); step(); step();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0) begin
            n_fail++;
            $display("FAIL idle_state: got ov=%b ir=%b data=%h want 0/1/0",
                     out_valid, in_ready, out_data);
        end
        n_checks++;
        if (bubble_cnt !== 16'd3 || stall_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL idle_cnt: got bubble=%0d stall=%0d want 3/0", bubble_cnt, stall_cnt);
        end
        n_checks++;
        if (out_data_s !== NOP_S) begin
            n_fail++;
            $display("FAIL idle_nop: got %h want %h", out_data_s, NOP_S);
        end
    endtask

    task automatic test_streaming();
        logic [W-1:0] vals [3];
        logic [15:0]  stall0;
        vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
        stall0 = stall_cnt;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = vals[i];
            step();
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== vals[i] || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_%0d: got ov=%b data=%h ir=%b want 1/%h/1",
                         i, out_valid, out_data, in_ready, vals[i]);
            end
        end
        in_valid = 1'b0;
        step();
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || stall_cnt !== stall0) begin
            n_fail++;
            $display("FAIL stream_drain: got ov=%b data=%h stall=%0d want 0/0/%0d",
                     out_valid, out_data, stall_cnt, stall0);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] stall0;
        stall0 = stall_cnt;
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hA; step();
        in_data = 32'hB; step();
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'hA) begin
            n_fail++;
            $display("FAIL skid_full: got ir=%b ov=%b data=%h want 0/1/a",
                     in_ready, out_valid, out_data);
        end
        in_data = 32'hC; step();
        n_checks++;
        if (in_ready !== 1'b0 || out_data !== 32'hA) begin
            n_fail++;
            $display("FAIL skid_hold: got ir=%b data=%h want 0/a", in_ready, out_data);
        end
        n_checks++;
        if (stall_cnt !== stall0 + 16'd2) begin
            n_fail++;
            $display("FAIL skid_stall: got %0d want %0d", stall_cnt, stall0 + 16'd2);
        end
        out_ready = 1'b1; step();
        n_checks++;
        if (out_data !== 32'hB || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL skid_order_b: got data=%h ir=%b want b/1", out_data, in_ready);
        end
        step();
        n_checks++;
        if (out_data !== 32'hC || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL skid_order_c: got data=%h ov=%b want c/1", out_data, out_valid);
        end
        in_valid = 1'b0; step();
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || stall_cnt !== stall0 + 16'd2) begin
            n_fail++;
            $display("FAIL skid_drain: got ov=%b data=%h stall=%0d", out_valid, out_data, stall_cnt);
        end
    endtask

    task automatic test_flush();
        logic [15:0] stall0, bubble0;
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 32'h1; step();
        in_data = 32'h2; step();
        stall0 = stall_cnt; bubble0 = bubble_cnt;
        Flush = 1'b1; in_data = 32'hD; step();
        Flush = 1'b0; in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_state: got ov=%b data=%h ir=%b want 0/0/1",
                     out_valid, out_data, in_ready);
        end
        // The flush cycle had out_valid=1, out_ready=0: still a stall cycle.
        n_checks++;
        if (stall_cnt !== stall0 + 16'd1 || bubble_cnt !== bubble0) begin
            n_fail++;
            $display("FAIL flush_cnt: got stall=%0d bubble=%0d want %0d/%0d",
                     stall_cnt, bubble_cnt, stall0 + 16'd1, bubble0);
        end
        n_checks++;
        if (out_data_s !== NOP_S) begin
            n_fail++;
            $display("FAIL flush_nop: got %h want %h", out_data_s, NOP_S);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_leak_%0d: got ov=%b data=%h want 0", i, out_valid, out_data);
            end
        end
    endtask

    task automatic test_reset_flush();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h77; step();
        Reset = 1'b1; Flush = 1'b1; in_data = 32'h88; step();
        Reset = 1'b0; Flush = 1'b0; in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0 ||
            stall_cnt !== 16'd0 || bubble_cnt !== 16'd0 || stall_s !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_flush: got ov=%b ir=%b data=%h stall=%0d bubble=%0d stall_s=%0d",
                     out_valid, in_ready, out_data, stall_cnt, bubble_cnt, stall_s);
        end
    endtask

    task automatic test_saturation();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h55; step();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) step();
        n_checks++;
        if (stall_s !== 4'd15) begin
            n_fail++;
            $display("FAIL sat_stall4: got %0d want 15", stall_s);
        end
        n_checks++;
        if (stall_cnt !== 16'd20) begin
            n_fail++;
            $display("FAIL sat_stall16: got %0d want 20", stall_cnt);
        end
        n_checks++;
        if (out_data_s !== 32'h55 || out_valid_s !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_hold: got ov=%b data=%h want 1/55", out_valid_s, out_data_s);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] exp_d, exp_ds;
        for (int i = 0; i < 600; i++) begin
            Reset     = ($urandom_range(0, 99) == 0);
            Flush     = ($urandom_range(0, 15) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_data   = $urandom;
            step();
            exp_d  = (mq.size() > 0) ? mq[0] : '0;
            exp_ds = (mq.size() > 0) ? mq[0] : NOP_S;
            n_checks++;
            if (out_valid !== (mq.size() > 0) || in_ready !== (mq.size() < 2) ||
                out_data !== exp_d) begin
                n_fail++;
                $display("FAIL rand_out_%0d: got ov=%b ir=%b data=%h want %b/%b/%h", i,
                         out_valid, in_ready, out_data, mq.size() > 0, mq.size() < 2, exp_d);
            end
            n_checks++;
            if (stall_cnt !== sat16(stall_raw) || bubble_cnt !== sat16(bubble_raw)) begin
                n_fail++;
                $display("FAIL rand_cnt_%0d: got stall=%0d bubble=%0d want %0d/%0d", i,
                         stall_cnt, bubble_cnt, sat16(stall_raw), sat16(bubble_raw));
            end
            n_checks++;
            if (out_data_s !== exp_ds || stall_s !== sat4(stall_raw) ||
                bubble_s !== sat4(bubble_raw)) begin
                n_fail++;
                $display("FAIL rand_sat_%0d: got data=%h stall=%0d bubble=%0d want %h/%0d/%0d", i,
                         out_data_s, stall_s, bubble_s, exp_ds, sat4(stall_raw), sat4(bubble_raw));
            end
        end
        Reset = 1'b0; Flush = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_reset_flush();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
